keypad_scanner: RTL

//  4x4 matrix keypad scanner/debouncer fed by the clock divider's sw_clk output (~23.84 Hz).
//  - Drives one column low at a time and samples the rows.
//  - Emits a debounced single-cycle key event plus a held level to downstream logic.
//  - Runs entirely in the clock_50m domain; sw_clk is used only as a sampled tick source.

---
 rtl/keypad_scanner_pkg.sv | 39 +++
 rtl/keypad_scanner_sync_edge_detect.sv | 28 ++
 rtl/keypad_scanner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned ROW_W    = 2;
    localparam int unsigned COL_W    = 2;
    localparam int unsigned KEY_W    = ROW_W + COL_W;
    localparam int unsigned CODE_W   = KEY_W + 1;

    // Internal scan codes carry a NONE flag in the MSB.
    localparam logic [CODE_W-1:0] KEY_NONE = 5'h10;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } state_e;

    // Number of asserted rows in one column, saturated at 2.
    function automatic logic [1:0] sat_hits(input logic [NUM_ROWS-1:0] hits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            n = n + 3'(hits[i]);
        end
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest asserted row (0 when none).
    function automatic logic [ROW_W-1:0] lowest_row(input logic [NUM_ROWS-1:0] hits);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (hits[i]) r = ROW_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_edge_detect.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module sync_edge_detect (
    input  logic clock_50m,
    input  logic reset_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    // Synchronise the input and flag a 0->1 transition for one cycle.
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_3     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_1     <= async_in;
            sync_2     <= sync_1;
            sync_3     <= sync_2;
            rise_pulse <= sync_2 & ~sync_3;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debounce and single-key press events.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 2
) (
    input  logic                clock_50m,
    input  logic                reset_n,
    input  logic                sw_clk,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    output logic                key_pressed
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic                tick;
    logic [NUM_ROWS-1:0] row_s1;
    logic [NUM_ROWS-1:0] row_s2;
    logic [COL_W-1:0]    col_idx;
    logic [COL_W-1:0]    col_idx_nxt;
    logic [1:0]          hit_cnt;
    logic [CODE_W-1:0]   first_code;
    logic [CODE_W-1:0]   prev_code;
    logic [CNT_W-1:0]    stable_cnt;
    logic                scan_done;

    logic [NUM_ROWS-1:0] row_hits;
    logic [1:0]          col_hits;
    logic [2:0]          hit_sum_raw;
    logic [1:0]          hit_sum;
    logic [CODE_W-1:0]   first_next;
    logic [CODE_W-1:0]   scan_code_c;

    state_e              state;
    state_e              state_nxt;
    logic [KEY_W-1:0]    key_code_nxt;
    logic                key_valid_nxt;
    logic                key_pressed_nxt;

    sync_edge_detect u_sw_clk_sync (
        .clock_50m  (clock_50m),
        .reset_n    (reset_n),
        .async_in   (sw_clk),
        .rise_pulse (tick)
    );

    // Two-flop synchroniser for the row inputs (idle level is all-high).
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
        end
    end

    // Fold the current column's rows into the running scan result.
    always_comb begin
        row_hits    = ~row_s2;
        col_hits    = sat_hits(row_hits);
        hit_sum_raw = {1'b0, hit_cnt} + {1'b0, col_hits};
        hit_sum     = (hit_sum_raw >= 3'd2) ? 2'd2 : hit_sum_raw[1:0];
        first_next  = first_code;
        if (hit_cnt == 2'd0 && col_hits != 2'd0) begin
            first_next = {1'b0, lowest_row(row_hits), col_idx};
        end
        scan_code_c = (hit_sum == 2'd1) ? first_next : KEY_NONE;
        col_idx_nxt = col_idx + 2'd1;
    end

    // Column stepping, per-scan accumulation and debounce at scan close.
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            col_idx    <= '0;
            col_n      <= 4'b1110;
            hit_cnt    <= '0;
            first_code <= KEY_NONE;
            prev_code  <= KEY_NONE;
            stable_cnt <= '0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (tick) begin
                col_idx <= col_idx_nxt;
                col_n   <= ~(4'b0001 << col_idx_nxt);
                if (col_idx == 2'd3) begin
                    hit_cnt    <= '0;
                    first_code <= KEY_NONE;
                    scan_done  <= 1'b1;
                    if (scan_code_c == prev_code) begin
                        if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + CNT_W'(1);
                    end else begin
                        stable_cnt <= CNT_W'(1);
                        prev_code  <= scan_code_c;
                    end
                end else begin
                    hit_cnt    <= hit_sum;
                    first_code <= first_next;
                end
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_code    <= key_code_nxt;
            key_valid   <= key_valid_nxt;
            key_pressed <= key_pressed_nxt;
        end
    end

    // Next state: act only on a freshly closed, fully debounced scan.
    always_comb begin
        state_nxt = state;
        if (scan_done && stable_cnt == CNT_MAX) begin
            case (state)
                IDLE:    if (!prev_code[CODE_W-1]) state_nxt = PRESSED;
                PRESSED: if (prev_code[CODE_W-1])  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output values: latch the code and pulse valid on entry to PRESSED.
    always_comb begin
        key_valid_nxt   = 1'b0;
        key_code_nxt    = key_code;
        key_pressed_nxt = (state_nxt == PRESSED);
        if (state == IDLE && state_nxt == PRESSED) begin
            key_valid_nxt = 1'b1;
            key_code_nxt  = prev_code[KEY_W-1:0];
        end
    end

endmodule
